// File: rtl/servo_positioner.sv
// servo_positioner: slews one hobby servo toward commanded angles,
// drives its PWM frame and reports moving / settled status.
module servo_positioner #(
    parameter int FRAME_TICKS   = 20000,
    parameter int PULSE_MIN     = 1000,
    parameter int TICKS_PER_DEG = 5,
    parameter int ANGLE_MAX     = 180,
    parameter int HOME_ANGLE    = 0,
    parameter int SETTLE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_angle,
    input  logic [31:0] speed,
    output logic [7:0]  position,
    output logic        moving,
    output logic        settled,
    output logic        pwm_out
);
    localparam int FW      = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam int PW_TOP  = PULSE_MIN + ANGLE_MAX * TICKS_PER_DEG;
    localparam int PW_BITS = $clog2(PW_TOP + 1);
    localparam int PWW     = (PW_BITS > 16) ? PW_BITS : 16;
    localparam int SW      = $clog2(SETTLE_FRAMES + 2);

    localparam logic [7:0]     AMAX   = 8'(ANGLE_MAX);
    localparam logic [7:0]     HOME   = 8'(HOME_ANGLE);
    localparam logic [FW-1:0]  FLAST  = FW'(FRAME_TICKS - 1);
    localparam logic [SW-1:0]  SLAST  = SW'(SETTLE_FRAMES);
    localparam logic [PWW-1:0] HOME_W = PWW'(PULSE_MIN + HOME_ANGLE * TICKS_PER_DEG);

    typedef enum logic [1:0] {
        HOLD,
        SLEW,
        IDLE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     position_q, position_d;
    logic [7:0]     target_q, target_d;
    logic [31:0]    step_len_q, step_len_d;
    logic [31:0]    step_cnt_q, step_cnt_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [FW-1:0]  frame_q, frame_d;
    logic [PWW-1:0] width_q, width_d;
    logic           pwm_q, pwm_d;
    logic           moving_q, moving_d;
    logic           settled_q, settled_d;
    logic           ready_q, ready_d;

    logic           accept;
    logic           frame_wrap;
    logic           step_hit;
    logic [7:0]     clamped;
    logic [7:0]     step_pos;
    logic [PWW-1:0] frame_width;

    assign accept      = cmd_valid && ready_q;
    assign frame_wrap  = (frame_q == FLAST);
    assign step_hit    = (step_cnt_q >= step_len_q - 32'd1);
    assign clamped     = (cmd_angle > AMAX) ? AMAX : cmd_angle;
    assign step_pos    = (target_q > position_q) ? position_q + 8'd1
                                                 : position_q - 8'd1;
    assign frame_width = PWW'(PULSE_MIN)
                       + PWW'(position_q) * PWW'(TICKS_PER_DEG);

    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        target_d   = target_q;
        step_len_d = step_len_q;
        step_cnt_d = step_cnt_q;
        settle_d   = settle_q;
        if (accept) begin
            target_d   = clamped;
            step_len_d = (speed == 32'd0) ? 32'd1 : speed;
            step_cnt_d = '0;
            settle_d   = '0;
            state_d    = (clamped != position_q) ? SLEW : HOLD;
        end else begin
            case (state_q)
                SLEW: begin
                    if (step_hit) begin
                        step_cnt_d = '0;
                        position_d = step_pos;
                        if (step_pos == target_q) begin
                            state_d  = HOLD;
                            settle_d = '0;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 32'd1;
                    end
                end
                HOLD: begin
                    if (settle_q >= SLAST) begin
                        state_d = IDLE;
                    end else if (frame_wrap) begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Width is sampled only at frame start so mid-frame moves cannot runt a pulse.
    always_comb begin
        frame_d   = frame_wrap ? '0 : frame_q + FW'(1);
        width_d   = (frame_q == '0) ? frame_width : width_q;
        pwm_d     = (32'(frame_q) < 32'(width_d));
        moving_d  = (state_d == SLEW);
        settled_d = (state_d == IDLE);
        ready_d   = (state_d != SLEW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            position_q <= HOME;
            target_q   <= HOME;
            step_len_q <= 32'd1;
            step_cnt_q <= '0;
            settle_q   <= '0;
            frame_q    <= '0;
            width_q    <= HOME_W;
            pwm_q      <= 1'b0;
            moving_q   <= 1'b0;
            settled_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            target_q   <= target_d;
            step_len_q <= step_len_d;
            step_cnt_q <= step_cnt_d;
            settle_q   <= settle_d;
            frame_q    <= frame_d;
            width_q    <= width_d;
            pwm_q      <= pwm_d;
            moving_q   <= moving_d;
            settled_q  <= settled_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign position  = position_q;
    assign moving    = moving_q;
    assign settled   = settled_q;
    assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_servo_positioner.sv
// tb_servo_positioner: scenario tasks against a timeline model of the
// servo (position as a function of cycles since the last accepted command).
module tb_servo_positioner;
    localparam int FT     = 200;
    localparam int PMIN   = 20;
    localparam int AMAX   = 180;
    localparam int SETTLE = 2;
    localparam int HMAX   = 32768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_angle = 8'd0;
    logic [31:0] speed = 32'd0;
    logic [7:0]  position;
    logic        moving;
    logic        settled;
    logic        pwm_out;

    servo_positioner #(
        .FRAME_TICKS(FT),
        .PULSE_MIN(PMIN),
        .TICKS_PER_DEG(1),
        .ANGLE_MAX(AMAX),
        .HOME_ANGLE(0),
        .SETTLE_FRAMES(SETTLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_angle(cmd_angle),
        .speed(speed),
        .position(position),
        .moving(moving),
        .settled(settled),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hist [HMAX];
    int m_p0, m_tgt, m_len, m_dist, m_a;
    int e_pos;
    bit e_mov, e_set, e_rdy, e_pwm;

    // Model: a command accepted at edge a from p0 moves one degree every
    // len edges until it reaches the target; settling needs two frame wraps
    // strictly after arrival, then one more edge.
    function automatic int arrive();
        return m_a + m_len * m_dist;
    endfunction

    function automatic int settle_edge(input int h);
        return (h / FT + SETTLE) * FT + 1;
    endfunction

    function automatic int mpos(input int n);
        int k;
        if (m_dist == 0) return m_p0;
        k = (n - m_a) / m_len;
        if (k > m_dist) k = m_dist;
        return (m_tgt > m_p0) ? m_p0 + k : m_p0 - k;
    endfunction

    function automatic void update();
        int m, f;
        e_pos = mpos(cyc);
        hist[cyc] = e_pos;
        e_mov = (m_dist > 0) && (cyc < arrive());
        e_rdy = !e_mov;
        e_set = !e_mov && (cyc >= settle_edge(arrive()));
        if (cyc == 0) begin
            e_pwm = 1'b0;
        end else begin
            m = cyc - 1;
            f = m % FT;
            e_pwm = (f < PMIN + hist[m - f]);
        end
    endfunction

    function automatic void model_reset();
        m_p0 = 0; m_tgt = 0; m_len = 1; m_dist = 0; m_a = 0;
        cyc = 0;
        update();
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (cyc >= HMAX) begin
            errors++;
            $display("FAIL cycle_budget got=%0d exp<%0d", cyc, HMAX);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
        update();
    endtask

    task automatic issue(input int ang, input int spd);
        cmd_valid = 1'b1;
        cmd_angle = 8'(ang);
        speed = 32'(spd);
        if (e_rdy) begin
            m_p0 = e_pos;
            m_tgt = (ang > AMAX) ? AMAX : ang;
            m_len = (spd < 1) ? 1 : spd;
            m_dist = (m_tgt > m_p0) ? m_tgt - m_p0 : m_p0 - m_tgt;
            m_a = cyc + 1;
        end
        tick();
        cmd_valid = 1'b0;
        cmd_angle = 8'($urandom);
        speed = $urandom_range(0, 9);
    endtask

    task automatic test_reset();
        int highs;
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL rst_pos got=%0d exp=0", position); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        checks++; if (settled !== 1'b0) begin errors++; $display("FAIL rst_settled got=%b exp=0", settled); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL rst_moving got=%b exp=0", moving); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm got=%b exp=0", pwm_out); end
        highs = 0;
        for (int i = 0; i < 2 * FT + 10; i++) begin
            tick();
            if (cyc <= FT) highs += int'(pwm_out);
            checks++; if (pwm_out !== e_pwm) begin errors++; $display("FAIL s1_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, e_pwm); end
            checks++; if (settled !== e_set) begin errors++; $display("FAIL s1_settled cyc=%0d got=%b exp=%b", cyc, settled, e_set); end
            checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL s1_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
        end
        checks++; if (highs != PMIN) begin errors++; $display("FAIL s1_pulse_len got=%0d exp=%0d", highs, PMIN); end
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL s1_settled_end got=%b exp=1", settled); end
    endtask

    task automatic test_slew();
        int a, h, fs, highs;
        checks++; if (settled !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL s2_idle got=%b%b exp=11", settled, cmd_ready); end
        issue(10, 3);
        a = cyc; h = arrive();
        checks++; if (cmd_ready !== 1'b0 || moving !== 1'b1) begin errors++; $display("FAIL s2_enter got=%b%b exp=01", cmd_ready, moving); end
        fs = ((h + FT - 1) / FT) * FT;
        highs = 0;
        while (cyc < settle_edge(h) + 2) begin
            tick();
            if (cyc > fs && cyc <= fs + FT) highs += int'(pwm_out);
            checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL s2_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
            checks++; if (moving !== e_mov) begin errors++; $display("FAIL s2_moving cyc=%0d got=%b exp=%b", cyc, moving, e_mov); end
            checks++; if (settled !== e_set) begin errors++; $display("FAIL s2_settled cyc=%0d got=%b exp=%b", cyc, settled, e_set); end
            checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL s2_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, e_rdy); end
            if (cyc == a + 29) begin
                checks++; if (position !== 8'd9 || moving !== 1'b1) begin errors++; $display("FAIL s2_before got=%0d/%b exp=9/1", position, moving); end
            end
            if (cyc == a + 30) begin
                checks++; if (position !== 8'd10 || moving !== 1'b0) begin errors++; $display("FAIL s2_arrive got=%0d/%b exp=10/0", position, moving); end
            end
        end
        checks++; if (highs != 30) begin errors++; $display("FAIL s2_pulse_len got=%0d exp=30", highs); end
    endtask

    task automatic test_clamp();
        int a, h, fs;
        bit all_high;
        issue(250, 0);
        a = cyc; h = arrive();
        fs = ((h + FT - 1) / FT) * FT;
        all_high = 1'b1;
        while (cyc < settle_edge(h) + 2) begin
            tick();
            if (cyc > fs && cyc <= fs + FT) all_high &= pwm_out;
            checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL s3_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
            checks++; if (pwm_out !== e_pwm) begin errors++; $display("FAIL s3_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, e_pwm); end
            checks++; if (moving !== e_mov) begin errors++; $display("FAIL s3_moving cyc=%0d got=%b exp=%b", cyc, moving, e_mov); end
            if (cyc == a + 169) begin
                checks++; if (position !== 8'd179) begin errors++; $display("FAIL s3_before got=%0d exp=179", position); end
            end
            if (cyc == a + 170) begin
                checks++; if (position !== 8'd180 || moving !== 1'b0) begin errors++; $display("FAIL s3_arrive got=%0d/%b exp=180/0", position, moving); end
            end
        end
        checks++; if (all_high !== 1'b1) begin errors++; $display("FAIL s3_const_high got=%b exp=1", all_high); end
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL s3_settled got=%b exp=1", settled); end
    endtask

    task automatic test_reverse();
        int a, h, minp;
        issue(175, 2);
        a = cyc; h = arrive();
        minp = 255;
        while (cyc < settle_edge(h) + 2) begin
            if (cyc == a + 4) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL s4_ready_mid got=%b exp=0", cmd_ready); end
                issue(0, 5);
            end else begin
                tick();
            end
            if (int'(position) < minp) minp = int'(position);
            checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL s4_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
            checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL s4_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, e_rdy); end
            if (cyc == a + 10) begin
                checks++; if (position !== 8'd175 || moving !== 1'b0) begin errors++; $display("FAIL s4_arrive got=%0d/%b exp=175/0", position, moving); end
            end
        end
        checks++; if (minp != 175) begin errors++; $display("FAIL s4_undershoot got=%0d exp=175", minp); end
        checks++; if (position !== 8'd175 || settled !== 1'b1) begin errors++; $display("FAIL s4_final got=%0d/%b exp=175/1", position, settled); end
    endtask

    task automatic test_same();
        int h;
        issue(175, 1);
        checks++; if (settled !== 1'b0 || moving !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL s5_hold got=%b%b%b exp=001", settled, moving, cmd_ready); end
        h = arrive();
        while (cyc < settle_edge(h) + 2) begin
            tick();
            checks++; if (settled !== e_set) begin errors++; $display("FAIL s5_settled cyc=%0d got=%b exp=%b", cyc, settled, e_set); end
            checks++; if (moving !== 1'b0) begin errors++; $display("FAIL s5_moving cyc=%0d got=%b exp=0", cyc, moving); end
        end
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL s5_reassert got=%b exp=1", settled); end
        issue(175, 1);
        for (int i = 0; i < 100; i++) tick();
        issue(170, 1);
        checks++; if (moving !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL s5_hold_accept got=%b%b exp=10", moving, cmd_ready); end
        h = arrive();
        while (cyc < settle_edge(h) + 2) begin
            tick();
            checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL s5_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
            checks++; if (settled !== e_set) begin errors++; $display("FAIL s5_settled2 cyc=%0d got=%b exp=%b", cyc, settled, e_set); end
        end
        checks++; if (position !== 8'd170) begin errors++; $display("FAIL s5_final got=%0d exp=170", position); end
    endtask

    task automatic test_random();
        int ang, spd, w;
        for (int k = 0; k < 12; k++) begin
            ang = $urandom_range(0, 255);
            spd = $urandom_range(0, 4);
            w = $urandom_range(0, 500);
            issue(ang, spd);
            for (int i = 0; i < w + 1; i++) begin
                tick();
                checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL rnd_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
                checks++; if (moving !== e_mov) begin errors++; $display("FAIL rnd_moving cyc=%0d got=%b exp=%b", cyc, moving, e_mov); end
                checks++; if (settled !== e_set) begin errors++; $display("FAIL rnd_settled cyc=%0d got=%b exp=%b", cyc, settled, e_set); end
                checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, e_rdy); end
                checks++; if (pwm_out !== e_pwm) begin errors++; $display("FAIL rnd_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, e_pwm); end
            end
        end
        for (int i = 0; i < 2000 && !e_set; i++) tick();
        checks++; if (settled !== 1'b1) begin errors++; $display("FAIL rnd_settle_end got=%b exp=1", settled); end
    endtask

    task automatic test_async_reset();
        issue(0, 0);
        for (int i = 0; i < 400 && e_mov; i++) tick();
        issue(100, 3);
        for (int i = 0; i < 400 && e_pos != 50; i++) begin
            tick();
            checks++; if (position !== 8'(e_pos)) begin errors++; $display("FAIL s6_pos cyc=%0d got=%0d exp=%0d", cyc, position, e_pos); end
        end
        checks++; if (position !== 8'd50 || moving !== 1'b1) begin errors++; $display("FAIL s6_mid got=%0d/%b exp=50/1", position, moving); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL s6_rst_pos got=%0d exp=0", position); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL s6_rst_pwm got=%b exp=0", pwm_out); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL s6_rst_moving got=%b exp=0", moving); end
        checks++; if (settled !== 1'b0) begin errors++; $display("FAIL s6_rst_settled got=%b exp=0", settled); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL s6_rst_ready got=%b exp=1", cmd_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        test_reset();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_slew();
        test_clamp();
        test_reverse();
        test_same();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
